// File: rtl/logic_ops_pkg.sv
// Shared opcode constants and FSM state encoding for the logic-op arbiter
// and its combinational logic unit.
package logic_ops_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational bitwise unit: AND / OR / NAND / NOR over WIDTH bits.
module logic_unit
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      default: y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_unit between NUM_REQ requesters.
// Define LOGIC_ARB_CNT_EN to add the saturating done_cnt completion counter.
module logic_op_arbiter
  import logic_ops_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
`ifdef LOGIC_ARB_CNT_EN
  ,
  parameter int CNT_W   = 16
`endif
  ,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [WIDTH*NUM_REQ-1:0]   req_a,
  input  logic [WIDTH*NUM_REQ-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [ID_W-1:0]            rsp_id
`ifdef LOGIC_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0]           done_cnt
`endif
);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q;
  logic [ID_W-1:0]  id_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] lu_y;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;

  logic [1:0]       op_arr [NUM_REQ];
  logic [WIDTH-1:0] a_arr  [NUM_REQ];
  logic [WIDTH-1:0] b_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[2*g +: 2];
    assign a_arr[g]  = req_a[WIDTH*g +: WIDTH];
    assign b_arr[g]  = req_b[WIDTH*g +: WIDTH];
  end

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    int              cand;
    logic [ID_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    if (state_q == ST_IDLE && !rst) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand     = (int'(last_grant_q) + k) % NUM_REQ;
        cand_idx = ID_W'(cand);
        if (!grant_found && req_valid[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_found) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_valid && rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (lu_y)
  );

  // Reset wipes the in-flight operation, so a reset in EXEC/RESP yields no response.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= '0;
    end else begin
      if (grant_found) begin
        op_q         <= op_arr[grant_idx];
        a_q          <= a_arr[grant_idx];
        b_q          <= b_arr[grant_idx];
        id_q         <= grant_idx;
        last_grant_q <= grant_idx;
      end
      if (state_q == ST_EXEC) begin
        rsp_valid <= 1'b1;
        rsp_data  <= lu_y;
        rsp_id    <= id_q;
      end else if (state_q == ST_RESP && rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_ARB_CNT_EN
  // Saturating count of completed response handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (state_q == ST_RESP && rsp_valid && rsp_ready && done_cnt != '1) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a behavioural reference model.
module tb_logic_op_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef LOGIC_ARB_CNT_EN
  localparam int CNT_W   = 2;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op = '0;
  logic [WIDTH*NUM_REQ-1:0] req_a = '0;
  logic [WIDTH*NUM_REQ-1:0] req_b = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
`ifdef LOGIC_ARB_CNT_EN
  logic [CNT_W-1:0]         done_cnt;
`endif

  logic_op_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ)
`ifdef LOGIC_ARB_CNT_EN
    ,
    .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef LOGIC_ARB_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester-side state: what each requester is currently offering.
  logic [NUM_REQ-1:0] pend = '0;
  logic [NUM_REQ-1:0] refill_mask = '0;
  logic [1:0]         op_m [NUM_REQ];
  logic [WIDTH-1:0]   a_m  [NUM_REQ];
  logic [WIDTH-1:0]   b_m  [NUM_REQ];

  // Reference model: phase 0 = free, 1 = computing, 2 = response offered.
  int             m_phase = 0;
  int             m_last  = NUM_REQ - 1;
  int             m_id    = 0;
  logic [WIDTH-1:0] m_y   = '0;
  int             n_hs    = 0;
  int             grant_log [$];
  logic [WIDTH-1:0] obs_data = '0;
  int             obs_id   = 0;

  function automatic logic [WIDTH-1:0] ref_logic(logic [1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int pick(logic [NUM_REQ-1:0] v, int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    pend[i] = 1'b1;
    op_m[i] = op;
    a_m[i]  = a;
    b_m[i]  = b;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = NUM_REQ - 1;
    n_hs    = 0;
  endtask

  // One clock cycle: drive, check outputs mid-cycle, clock, advance model.
  task automatic cycle(input logic rdy);
    logic [NUM_REQ-1:0] exp_ready;
    int g;
    req_valid = pend;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op[2*i +: 2]         = op_m[i];
      req_a[WIDTH*i +: WIDTH]  = a_m[i];
      req_b[WIDTH*i +: WIDTH]  = b_m[i];
    end
    rsp_ready = rdy;
    #1;
    exp_ready = '0;
    g = -1;
    if (m_phase == 0) begin
      g = pick(pend, m_last);
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    n_checks++;
    if (req_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL req_ready: got %b expected %b (t=%0t)", req_ready, exp_ready, $time);
    end
    n_checks++;
    if (rsp_valid !== (m_phase == 2)) begin
      n_fail++;
      $display("FAIL rsp_valid: got %b expected %0d (t=%0t)", rsp_valid, m_phase == 2, $time);
    end
    if (m_phase == 2) begin
      n_checks++;
      if (rsp_data !== m_y || rsp_id !== ID_W'(m_id)) begin
        n_fail++;
        $display("FAIL rsp_payload: got data=%h id=%0d expected data=%h id=%0d (t=%0t)",
                 rsp_data, rsp_id, m_y, m_id, $time);
      end
      obs_data = rsp_data;
      obs_id   = int'(rsp_id);
    end
`ifdef LOGIC_ARB_CNT_EN
    n_checks++;
    if (int'(done_cnt) != ((n_hs > 3) ? 3 : n_hs)) begin
      n_fail++;
      $display("FAIL done_cnt: got %0d expected %0d", done_cnt, (n_hs > 3) ? 3 : n_hs);
    end
`endif
    @(posedge clk);
    #1;
    case (m_phase)
      0: if (g >= 0) begin
        m_phase = 1;
        m_last  = g;
        m_id    = g;
        m_y     = ref_logic(op_m[g], a_m[g], b_m[g]);
        pend[g] = 1'b0;
        grant_log.push_back(g);
        if (refill_mask[g]) set_req(g, 2'($urandom), 8'($urandom), 8'($urandom));
      end
      1: m_phase = 2;
      default: if (rdy) begin
        m_phase = 0;
        n_hs++;
      end
    endcase
  endtask

  task automatic run_until_quiet(input int max_cycles);
    int c;
    c = 0;
    while ((pend != 0 || m_phase != 0) && c < max_cycles) begin
      cycle(1'b1);
      c++;
    end
    n_checks++;
    if (pend != 0 || m_phase != 0) begin
      n_fail++;
      $display("FAIL timeout: pend=%b phase=%0d after %0d cycles", pend, m_phase, c);
    end
  endtask

  task automatic do_reset(input int n);
    pend        = '0;
    refill_mask = '0;
    req_valid   = '0;
    rst         = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    repeat (2) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_values: ready=%b valid=%b data=%h id=%0d expected 0000/0/00/0",
                 req_ready, rsp_valid, rsp_data, rsp_id);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_grant: got %b expected 0001", req_ready);
    end
    // Withdraw before the edge: nothing may be captured.
    req_valid = '0;
    pend      = '0;
    model_reset();
    repeat (3) cycle(1'b1);
  endtask

  task automatic test_single();
    set_req(1, 2'b00, 8'hF0, 8'h3C);
    run_until_quiet(20);
    n_checks++;
    if (obs_data !== 8'h30 || obs_id != 1) begin
      n_fail++;
      $display("FAIL single: got data=%h id=%0d expected 30/1", obs_data, obs_id);
    end
  endtask

  task automatic test_opcodes();
    logic [WIDTH-1:0] exp_tab [4];
    exp_tab[0] = 8'h0A;
    exp_tab[1] = 8'hAF;
    exp_tab[2] = 8'hF5;
    exp_tab[3] = 8'h50;
    for (int op = 0; op < 4; op++) begin
      set_req(2, 2'(op), 8'hAA, 8'h0F);
      run_until_quiet(20);
      n_checks++;
      if (obs_data !== exp_tab[op] || obs_id != 2) begin
        n_fail++;
        $display("FAIL opcode%0d: got data=%h id=%0d expected %h/2", op, obs_data, obs_id, exp_tab[op]);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_a [6];
    int exp_b [3];
    exp_a = '{0, 1, 2, 3, 0, 1};
    exp_b = '{0, 3, 0};
    do_reset(1);
    grant_log.delete();
    refill_mask = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'($urandom), 8'($urandom), 8'($urandom));
    repeat (18) cycle(1'b1);
    refill_mask = '0;
    run_until_quiet(40);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (grant_log.size() <= k || grant_log[k] != exp_a[k]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", k,
                 (grant_log.size() > k) ? grant_log[k] : -1, exp_a[k]);
      end
    end
    do_reset(1);
    grant_log.delete();
    refill_mask = 4'b0001;
    set_req(0, 2'($urandom), 8'($urandom), 8'($urandom));
    set_req(3, 2'($urandom), 8'($urandom), 8'($urandom));
    repeat (9) cycle(1'b1);
    refill_mask = '0;
    run_until_quiet(20);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (grant_log.size() <= k || grant_log[k] != exp_b[k]) begin
        n_fail++;
        $display("FAIL rr_pair[%0d]: got %0d expected %0d", k,
                 (grant_log.size() > k) ? grant_log[k] : -1, exp_b[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] first_data;
    do_reset(1);
    grant_log.delete();
    set_req(1, 2'b01, 8'h12, 8'h40);
    set_req(2, 2'b11, 8'h0F, 8'h30);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b0);
    first_data = obs_data;
    repeat (4) cycle(1'b0);
    n_checks++;
    if (obs_data !== first_data || obs_data !== 8'h52 || obs_id != 1) begin
      n_fail++;
      $display("FAIL bp_hold: got data=%h id=%0d expected 52/1", obs_data, obs_id);
    end
    cycle(1'b1);
    cycle(1'b1);
    n_checks++;
    if (grant_log.size() != 2 || grant_log[1] != 2) begin
      n_fail++;
      $display("FAIL bp_next_grant: got log size %0d expected second grant 2", grant_log.size());
    end
    run_until_quiet(20);
  endtask

  task automatic test_reset_mid_op();
    do_reset(1);
    set_req(3, 2'b00, 8'hFF, 8'hFF);
    cycle(1'b1);
    pend      = '0;
    req_valid = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL midop_ready: got %b expected 0000", req_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_valid: got %b expected 0", rsp_valid);
    end
    rst = 1'b0;
    model_reset();
    repeat (8) cycle(1'b1);
  endtask

`ifdef LOGIC_ARB_CNT_EN
  task automatic test_counter();
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      set_req(k % NUM_REQ, 2'($urandom), 8'($urandom), 8'($urandom));
      run_until_quiet(20);
    end
    cycle(1'b1);
    n_checks++;
    if (done_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL cnt_saturate: got %0d expected 3", done_cnt);
    end
  endtask
`endif

  task automatic test_random();
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i] && ($urandom_range(0, 9) < 3))
          set_req(i, 2'($urandom), 8'($urandom), 8'($urandom));
      cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    run_until_quiet(60);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_m[i] = '0;
      a_m[i]  = '0;
      b_m[i]  = '0;
    end
    test_reset();
    test_single();
    test_opcodes();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
`ifdef LOGIC_ARB_CNT_EN
    test_counter();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares a single bitwise logic unit (AND/OR/NAND/NOR) between NUM_REQ requesters.
- Each requester presents an opcode and two WIDTH-bit operands on a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. Operands are captured and evaluated by the shared unit.
- The result is returned on one response channel, tagged with the requester ID.

Parameters:
- WIDTH, 8, operand/result bit width (>=1)
- NUM_REQ, 4, number of requesters (>=2)
- ID_W, $clog2(NUM_REQ), response ID width (localparam, derived)
- CNT_W, 16, completion counter width (used only with LOGIC_ARB_CNT_EN)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_op  in  2*NUM_REQ  opcode of requester i at [2i+1:2i]
- req_a  in  WIDTH*NUM_REQ  operand A of requester i at [WIDTH*i +: WIDTH]
- req_b  in  WIDTH*NUM_REQ  operand B, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  WIDTH  logic result
- rsp_id  out  ID_W  index of the requester that produced rsp_data
- done_cnt  out  CNT_W  completed-response count (present only with LOGIC_ARB_CNT_EN)

Behaviour:
- Opcodes: 2'b00 AND, 2'b01 OR, 2'b10 NAND (~(a&b)), 2'b11 NOR (~(a|b)). Bitwise across WIDTH; no carries, no width change.
- FSM states:
  - IDLE: req_ready is combinational. Search starts at (last_grant+1) mod NUM_REQ and wraps upward. The first i with req_valid[i]=1 gets req_ready[i]=1; all other bits are 0. On that cycle's edge, capture op/a/b of i into op_q/a_q/b_q, set id_q=i and last_grant=i, go to EXEC. With no valid request, stay in IDLE and keep req_ready=0.
  - EXEC: req_ready=0. Register rsp_data=logic_unit(op_q,a_q,b_q), rsp_id=id_q, rsp_valid=1. Go to RESP.
  - RESP: req_ready=0. rsp_valid, rsp_data and rsp_id are held stable. When rsp_valid&rsp_ready, clear rsp_valid and go to IDLE; otherwise stay.
- Latency: accept at edge T, rsp_valid high after edge T+1 (visible in the cycle after EXEC). Minimum spacing between accepts is 3 cycles.
- Requester protocol: req_valid/op/a/b stay stable until req_ready. The arbiter re-evaluates requests every IDLE cycle, so deasserting before grant is tolerated and nothing is latched from an unaccepted requester.
- Fairness: a requester that stays valid is granted within NUM_REQ grants.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=NUM_REQ-1 (so requester 0 wins first), req_ready=0 while rst=1, done_cnt=0.
- Reset during EXEC/RESP: the in-flight operation is discarded and no response is issued.
- rsp_ready high in IDLE/EXEC: ignored.

Optional Feature:
- LOGIC_ARB_CNT_EN defined: done_cnt port exists. It increments on each rsp_valid&rsp_ready, saturates at 2^CNT_W-1 and does not wrap. It clears on rst.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package logic_ops_pkg holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_NAND=2'b10, OP_NOR=2'b11
  - FSM state encodings ST_IDLE, ST_EXEC, ST_RESP (2 bits)
- Sub-module logic_unit (parameter WIDTH) is purely combinational: op, a, b in; y out. It is instantiated once in logic_op_arbiter.

Test Plan:
- Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0. After release the first grant is req_ready=4'b0001.
- Single request: req1 op=00 a=0xF0 b=0x3C, rsp_ready=1 -> accepted at T, rsp_valid at T+1 edge with rsp_data=0x30, rsp_id=1.
- Opcodes on a=0xAA b=0x0F from req2 -> AND 0x0A, OR 0xAF, NAND 0xF5, NOR 0x50, all with rsp_id=2.
- Round-robin: all 4 requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0,1. Only req0 and req3 valid after granting 0 -> next grant is 3, then 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/data/id stable, req_ready=0 throughout. rsp_ready=1 -> one handshake, then IDLE and the next grant.
- Reset mid-op: assert rst in EXEC -> next cycle rsp_valid=0 and no response is ever produced. With LOGIC_ARB_CNT_EN and CNT_W=2, five handshakes -> done_cnt=3.
